// File: rtl/gates_checker.sv
// Exhaustive 6-input sweep checker: drives every vector 0..63 into a gate network and compares it against a golden model.
// Latency: each vector is held SETTLE+1 cycles; done pulses 64*(SETTLE+1)+1 cycles after the start-sampling edge.
// Backpressure: none; start is only honoured in IDLE and ignored while a sweep is running.
module gates_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] vec,
  input  logic       dut_out_1,
  input  logic       dut_out_2,
  input  logic       exp_out_1,
  input  logic       exp_out_2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_cnt,
  output logic [5:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Wait-counter value on which the vector is considered settled.
  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic [5:0] vec_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       pass_nxt;
  logic [6:0] err_cnt_nxt;
  logic [5:0] first_fail_vec_nxt;
  logic       first_fail_valid_nxt;

  logic mismatch;
  logic last_vec;

  assign mismatch = ({dut_out_1, dut_out_2} != {exp_out_1, exp_out_2});
  assign last_vec = (vec == 6'd63);

  // State register; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> WAIT -> CMP -> (WAIT ... | DONE) -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = ST_CMP;
      ST_CMP:  state_nxt = last_vec ? ST_DONE : ST_WAIT;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the settle counter.
  always_comb begin
    vec_nxt              = vec;
    wait_cnt_nxt         = wait_cnt;
    busy_nxt             = busy;
    done_nxt             = 1'b0;
    pass_nxt             = pass;
    err_cnt_nxt          = err_cnt;
    first_fail_vec_nxt   = first_fail_vec;
    first_fail_valid_nxt = first_fail_valid;
    case (state)
      ST_IDLE: begin
        if (start) begin
          vec_nxt              = 6'd0;
          wait_cnt_nxt         = 4'd0;
          busy_nxt             = 1'b1;
          pass_nxt             = 1'b0;
          err_cnt_nxt          = 7'd0;
          first_fail_vec_nxt   = 6'd0;
          first_fail_valid_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt + 4'd1;
      end
      ST_CMP: begin
        if (mismatch) begin
          // At most 64 mismatches, so 7 bits never wrap.
          err_cnt_nxt = err_cnt + 7'd1;
          if (!first_fail_valid) begin
            first_fail_vec_nxt   = vec;
            first_fail_valid_nxt = 1'b1;
          end
        end
        if (last_vec) begin
          // vec parks at 63; verdict includes this final comparison.
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          pass_nxt = (err_cnt_nxt == 7'd0);
        end else begin
          vec_nxt      = vec + 6'd1;
          wait_cnt_nxt = 4'd0;
        end
      end
      ST_DONE: begin
        done_nxt = 1'b0;
      end
      default: begin
        done_nxt = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset clears all results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec              <= 6'd0;
      wait_cnt         <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= 7'd0;
      first_fail_vec   <= 6'd0;
      first_fail_valid <= 1'b0;
    end else begin
      vec              <= vec_nxt;
      wait_cnt         <= wait_cnt_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      err_cnt          <= err_cnt_nxt;
      first_fail_vec   <= first_fail_vec_nxt;
      first_fail_valid <= first_fail_valid_nxt;
    end
  end

endmodule

// File: doc/gates_checker.md
GATES_CHECKER -- requirements
Module: gates_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1: cycles each vector is held before its outputs are sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins a sweep when sampled high in IDLE.
REQ-005 The block SHALL have port vec, output, 6 bits: stimulus to the gate network; vec[5]..vec[0] drive a..f.
REQ-006 The block SHALL have ports dut_out_1 and dut_out_2, inputs, 1 bit each: gate-network responses.
REQ-007 The block SHALL have ports exp_out_1 and exp_out_2, inputs, 1 bit each: golden-model responses, combinational from vec.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-010 The block SHALL have port pass, output, 1 bit: sweep result, valid from the done cycle until the next start.
REQ-011 The block SHALL have port err_cnt, output, 7 bits: count of mismatching vectors, 0..64.
REQ-012 The block SHALL have port first_fail_vec, output, 6 bits: first mismatching vector.
REQ-013 The block SHALL have port first_fail_valid, output, 1 bit: qualifies first_fail_vec.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, CMP and DONE, with a 4-bit wait counter.
REQ-016 In IDLE with start=1, the next edge SHALL: enter WAIT; set vec=0 and wait counter=0; set busy=1; clear pass, err_cnt, first_fail_vec and first_fail_valid.
REQ-017 In WAIT, the wait counter SHALL increment each edge; on the edge where it equals SETTLE-1, the FSM SHALL enter CMP.
REQ-018 Each vector SHALL therefore occupy exactly SETTLE+1 cycles.
REQ-019 In CMP, a mismatch SHALL be {dut_out_1,dut_out_2} != {exp_out_1,exp_out_2}, sampled on the CMP edge.
REQ-020 On a mismatch, err_cnt SHALL increment; if first_fail_valid=0, first_fail_vec SHALL capture vec and first_fail_valid SHALL be set.
REQ-021 Later mismatches SHALL NOT change first_fail_vec.
REQ-022 In CMP with vec != 63, vec SHALL increment, the wait counter SHALL clear, and the FSM SHALL return to WAIT.
REQ-023 In CMP with vec == 63, the FSM SHALL enter DONE; vec SHALL hold 63, with no wrap.
REQ-024 In DONE, the block SHALL drive done=1 and busy=0, set pass=1 iff err_cnt==0 (counting the final CMP), then enter IDLE; done SHALL be high exactly one cycle.
REQ-025 The done pulse SHALL be high in the cycle 64*(SETTLE+1)+1 clocks after the start-sampling edge.
REQ-026 start SHALL be ignored in WAIT, CMP and DONE.
REQ-027 start high continuously SHALL cause back-to-back sweeps, each starting on the edge after DONE.
REQ-028 In IDLE, vec SHALL hold its last value; err_cnt, first_fail_vec, first_fail_valid and pass SHALL hold until the next start.
REQ-029 err_cnt SHALL NOT saturate or wrap; its maximum is 64.

Reset
REQ-030 With rst=1 at an edge, the block SHALL enter IDLE and drive vec=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0 and first_fail_valid=0.
REQ-031 rst SHALL take priority over start and over all FSM activity.
REQ-032 rst asserted mid-sweep SHALL abort the sweep with no done pulse; the next start SHALL run a full 64-vector sweep.

Verification
REQ-033 Bench scenario, reset/idle: rst for 2 cycles, start held 0 for 20 cycles -> all outputs 0 throughout.
REQ-034 Bench scenario, clean sweep: SETTLE=1, dut tied to exp, one start pulse -> busy for 128 cycles, done pulse at cycle 129, pass=1, err_cnt=0, first_fail_valid=0.
REQ-035 Bench scenario, single fault: dut_out_1 inverted only when vec==37 -> err_cnt=1, first_fail_vec=37, first_fail_valid=1, pass=0.
REQ-036 Bench scenario, stuck-at: exp_out_2=vec[0] and dut_out_2 tied 0 -> err_cnt=32, first_fail_vec=1, pass=0.
REQ-037 Bench scenario, abort: start pulsed at vec==10 (ignored), then rst at vec==20 -> next cycle all outputs 0 with no done; a new start gives a full sweep with done at cycle 129.
REQ-038 Bench scenario, SETTLE=3: each vector is held 4 cycles and the done pulse occurs at cycle 257; back-to-back start produces a second sweep beginning immediately after DONE.
